// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: halt FSM state encoding and
// the hard-wired zero register index.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALT   = 2'b01,
        ST_RESUME = 2'b10
    } wb_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_counter.sv
// Free-running wrap-around counter with enable and synchronous clear,
// used for the retired-instruction and cycle counters.
module wb_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register-file write mux, LED show latch, syscall halt FSM
// and retire counting. Define WB_PERF_CNT_EN to build the free-running cycle_cnt.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  status_in,
    input  logic                  show_in,
    input  logic                  syscall_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    input  logic                  jal_in,
    input  logic [DATA_W-1:0]     led_data_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic [DATA_W-1:0]     pc_and4_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  go,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  halt,
    output logic [DATA_W-1:0]     halt_pc,
    output logic [DATA_W-1:0]     led_out,
    output logic                  led_valid,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      cycle_cnt
);

    wb_state_e state, state_next;
    logic      retire;
    logic      sys_fire;
    logic      halt_fire;
    logic      show_fire;

    assign retire    = status_in & ~stall & (state != ST_HALT);
    // The held syscall is still in WB during RESUME; it must not re-trigger.
    assign sys_fire  = retire & syscall_in & (state == ST_RUN);
    assign halt_fire = sys_fire & ~show_in;
    assign show_fire = sys_fire & show_in;

    assign rf_waddr = write_reg_in;
    assign rf_we    = status_in & reg_write_in & (state != ST_HALT)
                    & (write_reg_in != REG_ADDR_W'(REG_ZERO));
    assign rf_wdata = jal_in        ? pc_and4_in  :
                      mem_to_reg_in ? mem_data_in : alu_result_in;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (halt_fire) state_next = ST_HALT;
            ST_HALT:   if (go) state_next = ST_RESUME;
            ST_RESUME: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            halt      <= 1'b0;
            halt_pc   <= '0;
            led_out   <= '0;
            led_valid <= 1'b0;
        end else begin
            state     <= state_next;
            halt      <= (state_next == ST_HALT);
            led_valid <= show_fire;
            if (halt_fire) halt_pc <= pc_in;
            if (show_fire) led_out <= led_data_in;
        end
    end

    wb_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (retire),
        .count (retired_cnt)
    );

`ifdef WB_PERF_CNT_EN
    wb_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (1'b1),
        .count (cycle_cnt)
    );
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_wb_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  status_in;
    logic                  show_in;
    logic                  syscall_in;
    logic                  mem_to_reg_in;
    logic                  reg_write_in;
    logic                  jal_in;
    logic [DATA_W-1:0]     led_data_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     pc_and4_in;
    logic [REG_ADDR_W-1:0] write_reg_in;
    logic [DATA_W-1:0]     pc_in;
    logic                  go;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  halt;
    logic [DATA_W-1:0]     halt_pc;
    logic [DATA_W-1:0]     led_out;
    logic                  led_valid;
    logic [CNT_W-1:0]      retired_cnt;
    logic [CNT_W-1:0]      cycle_cnt;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .status_in     (status_in),
        .show_in       (show_in),
        .syscall_in    (syscall_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .jal_in        (jal_in),
        .led_data_in   (led_data_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .pc_and4_in    (pc_and4_in),
        .write_reg_in  (write_reg_in),
        .pc_in         (pc_in),
        .go            (go),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .halt          (halt),
        .halt_pc       (halt_pc),
        .led_out       (led_out),
        .led_valid     (led_valid),
        .retired_cnt   (retired_cnt),
        .cycle_cnt     (cycle_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: "halted" = waiting for go; "resumed" = first cycle after go.
    bit               m_halted;
    bit               m_resumed;
    logic [DATA_W-1:0] m_halt_pc;
    logic [DATA_W-1:0] m_led;
    bit               m_led_valid;
    logic [CNT_W-1:0] m_retired;
    logic [CNT_W-1:0] m_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; status_in = 1'b0; show_in = 1'b0;
        syscall_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
        jal_in = 1'b0; go = 1'b0; write_reg_in = '0;
        led_data_in = '0; alu_result_in = '0; mem_data_in = '0;
        pc_and4_in = '0; pc_in = '0;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        bit ret;
        bit sys_eff;
        logic [DATA_W-1:0] exp_wdata;
        #1;
        if (!rst) begin
            exp_wdata = jal_in ? pc_and4_in : (mem_to_reg_in ? mem_data_in : alu_result_in);
            check("rf_we", rf_we, status_in && reg_write_in && write_reg_in != 0 && !m_halted);
            check("rf_wdata", rf_wdata, exp_wdata);
            check("rf_waddr", rf_waddr, write_reg_in);
        end
        @(posedge clk);
        if (rst) begin
            m_halted = 0; m_resumed = 0; m_halt_pc = '0; m_led = '0;
            m_led_valid = 0; m_retired = '0; m_cycles = '0;
        end else begin
            ret     = status_in && !stall && !m_halted;
            sys_eff = ret && syscall_in && !m_resumed;
            m_led_valid = sys_eff && show_in;
            if (sys_eff && show_in) m_led = led_data_in;
            if (sys_eff && !show_in) m_halt_pc = pc_in;
            if (ret) m_retired = m_retired + 1;
            m_cycles = m_cycles + 1;
            if (m_halted) begin
                m_resumed = go;
                m_halted  = !go;
            end else begin
                m_resumed = 0;
                m_halted  = sys_eff && !show_in;
            end
        end
        #1;
        check("halt", halt, m_halted);
        check("halt_pc", halt_pc, m_halt_pc);
        check("led_out", led_out, m_led);
        check("led_valid", led_valid, m_led_valid);
        check("retired_cnt", retired_cnt, m_retired);
`ifdef WB_PERF_CNT_EN
        check("cycle_cnt", cycle_cnt, m_cycles);
`else
        check("cycle_cnt", cycle_cnt, 0);
`endif
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        rst           = ($urandom_range(199) == 0);
        stall         = ($urandom_range(3) == 0);
        status_in     = ($urandom_range(9) < 8);
        syscall_in    = ($urandom_range(9) == 0);
        show_in       = $urandom_range(1);
        mem_to_reg_in = $urandom_range(1);
        reg_write_in  = $urandom_range(1);
        jal_in        = ($urandom_range(3) == 0);
        go            = ($urandom_range(4) == 0);
        write_reg_in  = REG_ADDR_W'($urandom_range(31));
        led_data_in   = $urandom;
        alu_result_in = $urandom;
        mem_data_in   = $urandom;
        pc_and4_in    = $urandom;
        pc_in         = $urandom;
    endtask

    logic [CNT_W-1:0] c0;

    initial begin
        m_halted = 0; m_resumed = 0; m_halt_pc = '0; m_led = '0;
        m_led_valid = 0; m_retired = '0; m_cycles = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_retired", retired_cnt, 0);
        check("reset_halt", halt, 0);

        // lw
        status_in = 1; reg_write_in = 1; mem_to_reg_in = 1;
        mem_data_in = 32'hDEADBEEF; alu_result_in = 32'h11111111; write_reg_in = 5'd8;
        #1;
        check("lw_we", rf_we, 1);
        check("lw_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        check("lw_cnt", retired_cnt, 1);

        // jal has priority over mem_to_reg; r0 never written
        jal_in = 1; pc_and4_in = 32'h3004; write_reg_in = 5'd31;
        #1;
        check("jal_wdata", rf_wdata, 32'h3004);
        check("jal_we", rf_we, 1);
        step();
        write_reg_in = 5'd0;
        #1;
        check("r0_we", rf_we, 0);
        step();

        // syscall halt
        idle();
        status_in = 1; syscall_in = 1; pc_in = 32'h3010;
        step();
        check("halt_set", halt, 1);
        check("halt_pc", halt_pc, 32'h3010);
        c0 = retired_cnt;
        stall = 1;
        repeat (3) step();
        check("halt_hold", halt, 1);
        check("halt_cnt_frozen", retired_cnt, c0);
        go = 1;
        step();
        check("halt_clear", halt, 0);
        check("go_cnt", retired_cnt, c0);
        go = 0; stall = 0;
        step();  // RESUME: held syscall must not halt again
        check("resume_no_halt", halt, 0);
        idle();
        step();

        // show
        status_in = 1; syscall_in = 1; show_in = 1; led_data_in = 32'h12345678;
        step();
        check("show_led", led_out, 32'h12345678);
        check("show_valid", led_valid, 1);
        check("show_no_halt", halt, 0);
        idle();
        step();
        check("show_pulse_end", led_valid, 0);

        // stall repeats an instruction; go in RUN ignored
        c0 = retired_cnt;
        status_in = 1; reg_write_in = 1; write_reg_in = 5'd3; alu_result_in = 32'h55; stall = 1; go = 1;
        repeat (3) step();
        stall = 0;
        step();
        check("stall_once", retired_cnt, c0 + 1);
        check("go_in_run", halt, 0);

        // reset during HALT
        idle();
        status_in = 1; syscall_in = 1; pc_in = 32'h4000;
        step();
        check("halt2_set", halt, 1);
        idle();
        rst = 1;
        step();
        rst = 0;
        check("rst_halt", halt, 0);
        check("rst_cnt", retired_cnt, 0);
        check("rst_cycle", cycle_cnt, 0);
        repeat (5) step();
`ifdef WB_PERF_CNT_EN
        check("cycle_k", cycle_cnt, 5);
`endif
        status_in = 1; syscall_in = 1; pc_in = 32'h4004;
        step();
        check("halt3_set", halt, 1);
        check("halt3_pc", halt_pc, 32'h4004);
        idle();
        go = 1;
        step();
        idle();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
